// File: rtl/md_unit_ctrl_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcode encoding,
// controller states, default latencies and opcode classification helpers.
package md_unit_ctrl_pkg;

  localparam int MD_OP_W = 4;
  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES = 10;

  typedef enum logic [MD_OP_W-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  function automatic logic is_start_op(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: is_start_op = 1'b1;
      default:                            is_start_op = 1'b0;
    endcase
  endfunction

  function automatic logic is_mult_op(input logic [MD_OP_W-1:0] op);
    case (op)
      MD_MULT, MD_MULTU: is_mult_op = 1'b1;
      default:           is_mult_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// E-stage to multiply/divide unit connection: opcode and operands in,
// busy indication and HI/LO read data out.
interface md_unit_ctrl_if import md_unit_ctrl_pkg::*; ();

  logic [MD_OP_W-1:0] mdOpE;
  logic [31:0]        in1E;
  logic [31:0]        in2E;
  logic               mdBusyE;
  logic [31:0]        hiLoOutE;

  modport master (
    output mdOpE,
    output in1E,
    output in2E,
    input  mdBusyE,
    input  hiLoOutE
  );

  modport slave (
    input  mdOpE,
    input  in1E,
    input  in2E,
    output mdBusyE,
    output hiLoOutE
  );

endinterface

// File: rtl/md_unit_ctrl_calc.sv
// Combinational {hi,lo} result for mult/multu/div/divu; a zero divisor or any
// other opcode passes the current HI/LO through unchanged.
module md_unit_ctrl_calc import md_unit_ctrl_pkg::*; (
  input  logic [MD_OP_W-1:0] op,
  input  logic [31:0]        in1,
  input  logic [31:0]        in2,
  input  logic [31:0]        hi_cur,
  input  logic [31:0]        lo_cur,
  output logic [63:0]        result
);

  logic [63:0] smul_s;
  logic [63:0] umul_s;
  logic        div_zero_s;
  logic [31:0] a_mag_s;
  logic [31:0] b_mag_s;
  logic [31:0] sden_s;
  logic [31:0] uden_s;
  logic [31:0] sq_mag_s;
  logic [31:0] sr_mag_s;
  logic [31:0] sq_s;
  logic [31:0] sr_s;
  logic [31:0] uq_s;
  logic [31:0] ur_s;

  // Low 64 bits of a product of sign-extended operands equal the signed product.
  assign smul_s = {{32{in1[31]}}, in1} * {{32{in2[31]}}, in2};
  assign umul_s = {32'd0, in1} * {32'd0, in2};

  // Signed divide on magnitudes so 0x80000000 / -1 wraps instead of trapping;
  // the divisor is forced to 1 when zero purely to keep the datapath defined.
  assign div_zero_s = (in2 == 32'd0);
  assign a_mag_s    = in1[31] ? (32'd0 - in1) : in1;
  assign b_mag_s    = in2[31] ? (32'd0 - in2) : in2;
  assign sden_s     = div_zero_s ? 32'd1 : b_mag_s;
  assign uden_s     = div_zero_s ? 32'd1 : in2;
  assign sq_mag_s   = a_mag_s / sden_s;
  assign sr_mag_s   = a_mag_s % sden_s;
  assign sq_s       = (in1[31] ^ in2[31]) ? (32'd0 - sq_mag_s) : sq_mag_s;
  assign sr_s       = in1[31] ? (32'd0 - sr_mag_s) : sr_mag_s;
  assign uq_s       = in1 / uden_s;
  assign ur_s       = in1 % uden_s;

  // Result select by opcode.
  always_comb begin
    result = {hi_cur, lo_cur};
    case (op)
      MD_MULT:  result = smul_s;
      MD_MULTU: result = umul_s;
      MD_DIV: begin
        if (div_zero_s) begin
          result = {hi_cur, lo_cur};
        end else begin
          result = {sr_s, sq_s};
        end
      end
      MD_DIVU: begin
        if (div_zero_s) begin
          result = {hi_cur, lo_cur};
        end else begin
          result = {ur_s, uq_s};
        end
      end
      default: result = {hi_cur, lo_cur};
    endcase
  end

endmodule

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer: fixed-latency busy counter, pending result
// registers and architectural HI/LO, with busy and mfhi/mflo read muxing.
module md_unit_ctrl import md_unit_ctrl_pkg::*; #(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input logic           clk,
  input logic           reset,
  md_unit_ctrl_if.slave md
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_state_e      state_r;
  md_state_e      state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] load_cnt_s;
  logic [31:0]    hi_r;
  logic [31:0]    lo_r;
  logic [31:0]    hi_nxt_s;
  logic [31:0]    lo_nxt_s;
  logic [31:0]    pend_hi_r;
  logic [31:0]    pend_lo_r;
  logic [31:0]    pend_hi_nxt_s;
  logic [31:0]    pend_lo_nxt_s;
  logic [63:0]    calc_s;
  logic           start_s;

  md_unit_ctrl_calc u_calc (
    .op     (md.mdOpE),
    .in1    (md.in1E),
    .in2    (md.in2E),
    .hi_cur (hi_r),
    .lo_cur (lo_r),
    .result (calc_s)
  );

  assign start_s    = is_start_op(md.mdOpE);
  assign load_cnt_s = is_mult_op(md.mdOpE) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);

  // Next-state logic: starts and MT writes only in IDLE; RUN ignores every opcode.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = cnt_r;
    hi_nxt_s      = hi_r;
    lo_nxt_s      = lo_r;
    pend_hi_nxt_s = pend_hi_r;
    pend_lo_nxt_s = pend_lo_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          pend_hi_nxt_s = calc_s[63:32];
          pend_lo_nxt_s = calc_s[31:0];
          cnt_nxt_s     = load_cnt_s;
          state_nxt_s   = ST_RUN;
        end else if (md.mdOpE == MD_MTHI) begin
          hi_nxt_s = md.in1E;
        end else if (md.mdOpE == MD_MTLO) begin
          lo_nxt_s = md.in1E;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == CNT_W'(1)) begin
          hi_nxt_s    = pend_hi_r;
          lo_nxt_s    = pend_lo_r;
          cnt_nxt_s   = {CNT_W{1'b0}};
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - CNT_W'(1);
        end
      end
      default: begin
        cnt_nxt_s   = {CNT_W{1'b0}};
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, counter, pending and HI/LO registers; reset cancels any running op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      hi_r      <= 32'd0;
      lo_r      <= 32'd0;
      pend_hi_r <= 32'd0;
      pend_lo_r <= 32'd0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      hi_r      <= hi_nxt_s;
      lo_r      <= lo_nxt_s;
      pend_hi_r <= pend_hi_nxt_s;
      pend_lo_r <= pend_lo_nxt_s;
    end
  end

  // Busy covers the start cycle combinationally so D stalls without a bubble.
  assign md.mdBusyE = start_s | (cnt_r != {CNT_W{1'b0}});

  // Architectural HI/LO read; old values are returned while a result is pending.
  always_comb begin
    md.hiLoOutE = 32'd0;
    case (md.mdOpE)
      MD_MFHI: md.hiLoOutE = hi_r;
      MD_MFLO: md.hiLoOutE = lo_r;
      default: md.hiLoOutE = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: each driven cycle queues its expected
// busy/read data; a negedge monitor pops and compares against the DUT.
module tb_md_unit_ctrl;
  import md_unit_ctrl_pkg::*;

  typedef struct {
    int          cyc;
    string       name;
    logic        busy;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  md_unit_ctrl_if mif ();

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation scheduled for the current cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      tests++;
      if (mif.mdBusyE !== mon_e.busy) begin
        fails++;
        $display("FAIL %s busy: got %b want %b (cycle %0d)", mon_e.name, mif.mdBusyE, mon_e.busy, cyc);
      end
      tests++;
      if (mif.hiLoOutE !== mon_e.data) begin
        fails++;
        $display("FAIL %s hiLoOutE: got %h want %h (cycle %0d)", mon_e.name, mif.hiLoOutE, mon_e.data, cyc);
      end
    end
  end

  task automatic step(input logic r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic eb, input logic [31:0] ed, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset    = r;
    mif.mdOpE = op;
    mif.in1E  = a;
    mif.in2E  = b;
    e.cyc  = cyc;
    e.name = nm;
    e.busy = eb;
    e.data = ed;
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic eb, input logic [31:0] ed, input string nm);
    for (int i = 0; i < n; i++) step(1'b0, op, a, b, eb, ed, nm);
  endtask

  initial begin
    mif.mdOpE = MD_NONE;
    mif.in1E  = 32'd0;
    mif.in2E  = 32'd0;
    repeat (2) @(posedge clk);

    // Reset state
    step(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0, 32'd0, "rst_idle");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'd0, "rst_hi");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, "rst_lo");

    // Signed mult -1*2: 6 busy cycles, old HI readable until commit
    step(1'b0, MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, 32'd0, "mult_start");
    run(5, MD_MFHI, 32'd0, 32'd0, 1'b1, 32'd0, "mult_run");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, "mult_hi");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFE, "mult_lo");

    // Unsigned mult
    step(1'b0, MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b1, 32'd0, "multu_start");
    run(5, MD_MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, "multu_run_oldhi");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h00000001, "multu_hi");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFE, "multu_lo");

    // Signed div -7/2
    step(1'b0, MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'd0, "div_start");
    run(10, MD_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFE, "div_run");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFD, "div_lo");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, "div_hi");

    // divu by zero: full latency, HI/LO unchanged
    step(1'b0, MD_DIVU, 32'd7, 32'd0, 1'b1, 32'd0, "divz_start");
    run(10, MD_MFHI, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFF, "divz_run");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, "divz_hi");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFD, "divz_lo");

    // MTHI then MFHI; MTLO during a div is ignored
    step(1'b0, MD_MTHI, 32'h00001234, 32'd0, 1'b0, 32'd0, "mthi");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h00001234, "mthi_rd");
    step(1'b0, MD_DIV, 32'd100, 32'd7, 1'b1, 32'd0, "div2_start");
    run(2, MD_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFD, "div2_run");
    step(1'b0, MD_MTLO, 32'h0000DEAD, 32'd0, 1'b1, 32'd0, "div2_mtlo");
    run(7, MD_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFD, "div2_run2");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h0000000E, "div2_lo");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h00000002, "div2_hi");

    // Signed div with negative divisor: 7 / -2 -> q=-3, r=1
    step(1'b0, MD_DIV, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd0, "div3_start");
    run(10, MD_MFHI, 32'd0, 32'd0, 1'b1, 32'h00000002, "div3_run");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'hFFFFFFFD, "div3_lo");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h00000001, "div3_hi");

    // Overflow case wraps
    step(1'b0, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, "divov_start");
    run(10, MD_MFLO, 32'd0, 32'd0, 1'b1, 32'hFFFFFFFD, "divov_run");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h80000000, "divov_lo");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h00000000, "divov_hi");

    // Reset at cnt==3 during mult cancels the op and clears HI/LO
    step(1'b0, MD_MTHI, 32'h00005555, 32'd0, 1'b0, 32'd0, "pre_rst_mthi");
    step(1'b0, MD_MULT, 32'd3, 32'd4, 1'b1, 32'd0, "rstmid_start");
    run(2, MD_MFHI, 32'd0, 32'd0, 1'b1, 32'h00005555, "rstmid_run");
    step(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b1, 32'h00005555, "rstmid_assert");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'd0, "rstmid_hi");
    run(6, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'd0, "rstmid_lo");

    // Held MULT: ignored at the 1->0 edge, accepted on the following IDLE cycle
    step(1'b0, MD_MULT, 32'd3, 32'd4, 1'b1, 32'd0, "b2b_start");
    run(5, MD_MULT, 32'd3, 32'd4, 1'b1, 32'd0, "b2b_held");
    step(1'b0, MD_MULT, 32'd5, 32'd4, 1'b1, 32'd0, "b2b_restart");
    run(5, MD_MFLO, 32'd0, 32'd0, 1'b1, 32'h0000000C, "b2b_run");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h00000014, "b2b_lo");
    step(1'b0, MD_MFHI, 32'd0, 32'd0, 1'b0, 32'h00000000, "b2b_hi");

    // Unknown opcodes: no effect, zero read data
    step(1'b0, 4'd12, 32'hAAAAAAAA, 32'h1, 1'b0, 32'd0, "unk12");
    step(1'b0, 4'd15, 32'hAAAAAAAA, 32'h1, 1'b0, 32'd0, "unk15");
    step(1'b0, MD_MFLO, 32'd0, 32'd0, 1'b0, 32'h00000014, "unk_lo");

    @(posedge clk);
    #1;
    mif.mdOpE = MD_NONE;
    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
